// File: rtl/usb_tx_packet_sequencer.sv
// Sequences one USB TX packet (SYNC, PID, payload, CRC16, EOP) from the TX FIFO to the serializer.
// Optional feature: define USB_TX_CRC16_EN for a real CRC16; otherwise both CRC bytes are sent as 8'h00.
`timescale 1ns/1ps
module usb_tx_packet_sequencer #(
  parameter int          MAX_PAYLOAD = 64,
  parameter logic [7:0]  SYNC_BYTE   = 8'h80
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        tx_start,
  input  logic [3:0]  tx_pid,
  input  logic [6:0]  buffer_occupancy,
  input  logic [7:0]  tx_packet_data,
  input  logic        tx_byte_ready,
  output logic        get_tx_packet_data,
  output logic [7:0]  tx_byte,
  output logic        tx_byte_valid,
  output logic        tx_eop,
  output logic        tx_busy,
  output logic        tx_done,
  output logic [9:0]  packet_counter_TX
);

  localparam logic [6:0] MAX_LEN = 7'(MAX_PAYLOAD);

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_PID, S_FETCH, S_DATA, S_CRC_LO, S_CRC_HI, S_EOP, S_DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  pid_reg, pid_next;
  logic [6:0]  rem_reg, rem_next;
  logic [7:0]  hold_reg, hold_next;
  logic        first_reg, first_next;
  logic [9:0]  count_reg, count_next;
  logic [6:0]  len_clamped;
  logic [7:0]  data_byte;
  logic [15:0] crc_tx;

  assign len_clamped = (buffer_occupancy > MAX_LEN) ? MAX_LEN : buffer_occupancy;
  // FIFO data arrives on the first DATA cycle; later cycles replay the held copy.
  assign data_byte   = first_reg ? tx_packet_data : hold_reg;

`ifdef USB_TX_CRC16_EN
  logic [15:0] crc_reg;
  logic [15:0] crc_upd;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_crc
      logic [15:0] c_in;
      logic [15:0] c_out;
      if (gi == 0) begin : g_first
        assign c_in = crc_reg ^ {8'h00, data_byte};
      end else begin : g_next
        assign c_in = g_crc[gi-1].c_out;
      end
      assign c_out = c_in[0] ? ((c_in >> 1) ^ 16'hA001) : (c_in >> 1);
    end
  endgenerate
  assign crc_upd = g_crc[7].c_out;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      crc_reg <= 16'h0000;
    end else if (state_reg == S_IDLE && tx_start) begin
      crc_reg <= 16'hFFFF;
    end else if (state_reg == S_DATA && tx_byte_ready) begin
      crc_reg <= crc_upd;
    end
  end
  assign crc_tx = ~crc_reg;
`else
  assign crc_tx = 16'h0000;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= S_IDLE;
      pid_reg   <= 4'h0;
      rem_reg   <= 7'd0;
      hold_reg  <= 8'h00;
      first_reg <= 1'b0;
      count_reg <= 10'd0;
    end else begin
      state_reg <= state_next;
      pid_reg   <= pid_next;
      rem_reg   <= rem_next;
      hold_reg  <= hold_next;
      first_reg <= first_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    pid_next           = pid_reg;
    rem_next           = rem_reg;
    hold_next          = hold_reg;
    first_next         = 1'b0;
    count_next         = count_reg;
    get_tx_packet_data = 1'b0;
    tx_byte            = 8'h00;
    tx_byte_valid      = 1'b0;
    tx_eop             = 1'b0;
    tx_done            = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (tx_start) begin
          pid_next   = tx_pid;
          rem_next   = len_clamped;
          count_next = 10'd0;
          state_next = S_SYNC;
        end
      end
      S_SYNC: begin
        tx_byte       = SYNC_BYTE;
        tx_byte_valid = 1'b1;
        if (tx_byte_ready) state_next = S_PID;
      end
      S_PID: begin
        tx_byte       = {~pid_reg, pid_reg};
        tx_byte_valid = 1'b1;
        if (tx_byte_ready) begin
          if (pid_reg[1:0] == 2'b11) state_next = (rem_reg != 7'd0) ? S_FETCH : S_CRC_LO;
          else                       state_next = S_EOP;
        end
      end
      S_FETCH: begin
        get_tx_packet_data = 1'b1;
        first_next         = 1'b1;
        state_next         = S_DATA;
      end
      S_DATA: begin
        tx_byte       = data_byte;
        tx_byte_valid = 1'b1;
        if (first_reg) hold_next = tx_packet_data;
        if (tx_byte_ready) begin
          rem_next   = rem_reg - 7'd1;
          state_next = (rem_reg == 7'd1) ? S_CRC_LO : S_FETCH;
        end
      end
      S_CRC_LO: begin
        tx_byte       = crc_tx[7:0];
        tx_byte_valid = 1'b1;
        if (tx_byte_ready) state_next = S_CRC_HI;
      end
      S_CRC_HI: begin
        tx_byte       = crc_tx[15:8];
        tx_byte_valid = 1'b1;
        if (tx_byte_ready) state_next = S_EOP;
      end
      S_EOP: begin
        tx_eop     = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        tx_done    = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (tx_byte_valid && tx_byte_ready && count_reg != 10'h3FF) count_next = count_reg + 10'd1;
  end

  assign tx_busy           = (state_reg != S_IDLE);
  assign packet_counter_TX = count_reg;

endmodule
